// File: rtl/mem_pkg.sv
// Shared packet-buffer memory parameters and free-list state encoding.
package mem_pkg;

  localparam int unsigned NUM_BLOCKS = 1024;
  localparam int unsigned ADDR_W     = $clog2(NUM_BLOCKS);
  localparam int unsigned BLOCK_BITS = 512;

  typedef enum logic {
    FL_INIT,
    FL_READY
  } fl_state_e;

endpackage

// File: rtl/fl_ram.sv
// Simple dual-port RAM: one synchronous write port, one asynchronous read port, no reset.
module fl_ram #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned WIDTH  = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/free_list_ctrl.sv
// Free-list controller: circular queue of free block indices plus allocated-block bitmap,
// self-initialising after reset, with occupancy, low-watermark and sticky protocol errors.
module free_list_ctrl #(
  parameter int unsigned NUM_BLOCKS = mem_pkg::NUM_BLOCKS,
  parameter int unsigned ADDR_W     = $clog2(NUM_BLOCKS),
  parameter int unsigned LOW_WM     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fl_alloc_req_i,
  output logic              fl_alloc_gnt_o,
  output logic [ADDR_W-1:0] fl_alloc_block_idx_o,
  input  logic              free_req_i,
  input  logic [ADDR_W-1:0] free_block_idx_i,
  output logic              fl_ready_o,
  output logic [ADDR_W:0]   free_count_o,
  output logic              fl_low_o,
  output logic              err_double_free_o,
  output logic              err_underflow_o
);
  import mem_pkg::*;

  fl_state_e             state_q, state_d;
  logic [ADDR_W-1:0]     init_cnt_q, init_cnt_d;
  logic [ADDR_W-1:0]     head_q, head_d;
  logic [ADDR_W-1:0]     tail_q, tail_d;
  logic [ADDR_W:0]       count_q, count_d;
  logic [NUM_BLOCKS-1:0] alloc_map_q, alloc_map_d;
  logic                  low_q, low_d;
  logic                  err_df_q, err_df_d;
  logic                  err_uf_q, err_uf_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [ADDR_W-1:0] ram_wdata;
  logic [ADDR_W-1:0] ram_rdata;

  logic is_ready;
  logic cnt_nz;
  logic alloc_gnt;
  logic free_ok;

  fl_ram #(
    .ADDR_W (ADDR_W),
    .WIDTH  (ADDR_W)
  ) u_fl_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (head_q),
    .rdata (ram_rdata)
  );

  assign is_ready  = (state_q == FL_READY);
  assign cnt_nz    = (count_q != '0);
  assign alloc_gnt = is_ready && fl_alloc_req_i && cnt_nz;
  // Checked against the pre-edge bitmap, so a same-cycle alloc of this index does not count.
  assign free_ok   = is_ready && free_req_i && alloc_map_q[free_block_idx_i];

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    alloc_map_d = alloc_map_q;
    err_df_d    = err_df_q;
    err_uf_d    = err_uf_q;
    ram_we      = 1'b0;
    ram_waddr   = tail_q;
    ram_wdata   = free_block_idx_i;

    unique case (state_q)
      FL_INIT: begin
        ram_we     = 1'b1;
        ram_waddr  = init_cnt_q;
        ram_wdata  = init_cnt_q;
        init_cnt_d = init_cnt_q + 1'b1;
        tail_d     = tail_q + 1'b1;
        count_d    = count_q + 1'b1;
        if (init_cnt_q == ADDR_W'(NUM_BLOCKS - 1)) begin
          state_d = FL_READY;
        end
        if (free_req_i) begin
          err_df_d = 1'b1;
        end
      end

      FL_READY: begin
        if (alloc_gnt) begin
          head_d                 = head_q + 1'b1;
          alloc_map_d[ram_rdata] = 1'b1;
        end
        if (free_ok) begin
          ram_we                        = 1'b1;
          tail_d                        = tail_q + 1'b1;
          alloc_map_d[free_block_idx_i] = 1'b0;
        end
        unique case ({free_ok, alloc_gnt})
          2'b10:   count_d = count_q + 1'b1;
          2'b01:   count_d = count_q - 1'b1;
          default: count_d = count_q;
        endcase
        if (free_req_i && !free_ok) begin
          err_df_d = 1'b1;
        end
        if (fl_alloc_req_i && !cnt_nz) begin
          err_uf_d = 1'b1;
        end
      end

      default: state_d = FL_INIT;
    endcase
  end

  assign low_d = (32'(count_d) < LOW_WM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FL_INIT;
      init_cnt_q  <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      alloc_map_q <= '0;
      low_q       <= 1'b1;
      err_df_q    <= 1'b0;
      err_uf_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      alloc_map_q <= alloc_map_d;
      low_q       <= low_d;
      err_df_q    <= err_df_d;
      err_uf_q    <= err_uf_d;
    end
  end

  assign fl_ready_o           = is_ready;
  assign fl_alloc_gnt_o       = alloc_gnt;
  assign fl_alloc_block_idx_o = cnt_nz ? ram_rdata : '0;
  assign free_count_o         = count_q;
  assign fl_low_o             = low_q;
  assign err_double_free_o    = err_df_q;
  assign err_underflow_o      = err_uf_q;

  // Bitmap gating must keep the queue from ever overfilling.
  count_bound_a: assert property (@(posedge clk) disable iff (!rst_n)
    32'(count_q) <= NUM_BLOCKS);

endmodule

// File: tb/tb_free_list_ctrl.sv
// Self-checking bench for free_list_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_free_list_ctrl;

  localparam int NB = 8;
  localparam int AW = 3;
  localparam int LW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic          gnt;
  logic [AW-1:0] idx;
  logic          free_req = 1'b0;
  logic [AW-1:0] fidx = '0;
  logic          ready;
  logic [AW:0]   cnt;
  logic          low;
  logic          edf;
  logic          euf;

  int n_tests = 0;
  int n_fail  = 0;

  free_list_ctrl #(
    .NUM_BLOCKS (NB),
    .ADDR_W     (AW),
    .LOW_WM     (LW)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .fl_alloc_req_i       (req),
    .fl_alloc_gnt_o       (gnt),
    .fl_alloc_block_idx_o (idx),
    .free_req_i           (free_req),
    .free_block_idx_i     (fidx),
    .fl_ready_o           (ready),
    .free_count_o         (cnt),
    .fl_low_o             (low),
    .err_double_free_o    (edf),
    .err_underflow_o      (euf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: the free list is a plain FIFO of indices plus an ownership array.
  bit m_ready = 1'b0;
  int m_init  = 0;
  int m_q[$];
  bit m_alloc[NB];
  bit m_low   = 1'b1;
  bit m_edf   = 1'b0;
  bit m_euf   = 1'b0;

  function automatic int m_count();
    return m_ready ? m_q.size() : m_init;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit g;
    bit ok;
    int n;
    if (!rst_n) begin
      m_ready = 1'b0;
      m_init  = 0;
      m_q.delete();
      foreach (m_alloc[i]) m_alloc[i] = 1'b0;
      m_low   = 1'b1;
      m_edf   = 1'b0;
      m_euf   = 1'b0;
    end else if (!m_ready) begin
      if (free_req) m_edf = 1'b1;
      m_init++;
      if (m_init == NB) begin
        m_ready = 1'b1;
        for (int i = 0; i < NB; i++) m_q.push_back(i);
      end
      m_low = (m_init < LW);
    end else begin
      g  = req && (m_q.size() != 0);
      ok = free_req && m_alloc[fidx];
      if (req && m_q.size() == 0) m_euf = 1'b1;
      if (free_req && !ok) m_edf = 1'b1;
      if (g) begin
        n = m_q.pop_front();
        m_alloc[n] = 1'b1;
      end
      if (ok) begin
        m_q.push_back(int'(fidx));
        m_alloc[fidx] = 1'b0;
      end
      m_low = (m_q.size() < LW);
    end
  end

  always @(negedge clk) begin : compare
    bit eg;
    eg = m_ready && req && (m_q.size() != 0);
    chk("cmp_gnt", 32'(gnt), 32'(eg));
    if (eg) chk("cmp_idx", 32'(idx), m_q[0]);
    chk("cmp_ready", 32'(ready), 32'(m_ready));
    chk("cmp_count", 32'(cnt), m_count());
    chk("cmp_low", 32'(low), 32'(m_low));
    chk("cmp_err_df", 32'(edf), 32'(m_edf));
    chk("cmp_err_uf", 32'(euf), 32'(m_euf));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pick[$];
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Initialisation
    chk("rst_ready", 32'(ready), 0);
    chk("rst_count", 32'(cnt), 0);
    chk("rst_low", 32'(low), 1);
    repeat (7) cyc();
    chk("init_not_ready", 32'(ready), 0);
    cyc();
    chk("init_ready", 32'(ready), 1);
    chk("init_count", 32'(cnt), 8);
    chk("init_low", 32'(low), 0);
    chk("model_init_count", m_count(), 8);

    // Drain in order, then underflow
    req = 1'b1;
    for (int i = 0; i < NB; i++) begin
      #1;
      chk("drain_gnt", 32'(gnt), 1);
      chk("drain_idx", 32'(idx), i);
      cyc();
      if (i == NB - 2) chk("drain_low_at_1", 32'(low), 1);
    end
    chk("drain_count", 32'(cnt), 0);
    chk("model_drain_count", m_count(), 0);
    #1;
    chk("underflow_gnt", 32'(gnt), 0);
    cyc();
    chk("underflow_flag", 32'(euf), 1);
    req = 1'b0;

    // FIFO order of returned blocks
    free_req = 1'b1; fidx = 3'd5;
    cyc();
    chk("fifo_cnt1", 32'(cnt), 1);
    fidx = 3'd2;
    cyc();
    chk("fifo_cnt2", 32'(cnt), 2);
    free_req = 1'b0; req = 1'b1;
    #1;
    chk("fifo_idx5", 32'(idx), 5);
    cyc();
    chk("fifo_cnt3", 32'(cnt), 1);
    #1;
    chk("fifo_idx2", 32'(idx), 2);
    cyc();
    chk("fifo_cnt4", 32'(cnt), 0);

    // No bypass of a freed block at count 0
    free_req = 1'b1; fidx = 3'd3;
    #1;
    chk("nobypass_gnt0", 32'(gnt), 0);
    cyc();
    free_req = 1'b0;
    #1;
    chk("nobypass_gnt1", 32'(gnt), 1);
    chk("nobypass_idx", 32'(idx), 3);
    cyc();
    req = 1'b0;

    // Simultaneous alloc/free, then double free
    free_req = 1'b1;
    fidx = 3'd0; cyc();
    fidx = 3'd1; cyc();
    fidx = 3'd4; cyc();
    fidx = 3'd6; cyc();
    chk("sim_cnt_before", 32'(cnt), 4);
    chk("sim_edf_before", 32'(edf), 0);
    fidx = 3'd7; req = 1'b1;
    #1;
    chk("sim_idx", 32'(idx), 0);
    cyc();
    chk("sim_cnt_after", 32'(cnt), 4);
    req = 1'b0;
    cyc();
    chk("dbl_free_flag", 32'(edf), 1);
    chk("dbl_free_cnt", 32'(cnt), 4);
    chk("model_dbl_q", m_q.size(), 4);
    free_req = 1'b0;

    // Reset mid-allocation
    req = 1'b1;
    cyc();
    chk("midrst_cnt3", 32'(cnt), 3);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(ready), 0);
    chk("midrst_gnt", 32'(gnt), 0);
    chk("midrst_cnt", 32'(cnt), 0);
    chk("midrst_low", 32'(low), 1);
    chk("midrst_edf", 32'(edf), 0);
    chk("midrst_euf", 32'(euf), 0);
    req = 1'b0;
    cyc();
    rst_n = 1'b1;
    repeat (8) cyc();
    chk("reinit_ready", 32'(ready), 1);
    free_req = 1'b1; fidx = 3'd0;
    cyc();
    free_req = 1'b0;
    chk("reinit_dbl_free", 32'(edf), 1);
    chk("reinit_cnt", 32'(cnt), 8);

    // Randomized traffic, frees biased toward currently allocated blocks
    repeat (3000) begin
      req      = ($urandom_range(0, 99) < 55);
      free_req = ($urandom_range(0, 99) < 45);
      pick.delete();
      foreach (m_alloc[i]) if (m_alloc[i]) pick.push_back(i);
      if (pick.size() != 0 && $urandom_range(0, 9) < 8)
        fidx = AW'(pick[$urandom_range(0, pick.size() - 1)]);
      else
        fidx = AW'($urandom_range(0, NB - 1));
      rst_n = ($urandom_range(0, 399) != 0);
      cyc();
    end
    rst_n = 1'b1; req = 1'b0; free_req = 1'b0;
    repeat (2) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
